// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, access-size
// encodings and the memory-port enable codes, plus small encoding helpers.
package lsu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STORE    = 3'd1,
        LD_ISSUE = 3'd2,
        LD_CAPT  = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    // Access size as presented on req_size
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Memory write-enable codes
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_WORD = 2'b10;

    // Memory read-size codes; RE_BYTE doubles as the idle value
    localparam logic [1:0] RE_BYTE = 2'b00;
    localparam logic [1:0] RE_WORD = 2'b01;

    function automatic logic [1:0] we_code(input logic size);
        return (size == SIZE_WORD) ? WE_WORD : WE_BYTE;
    endfunction

    function automatic logic [1:0] re_code(input logic size);
        return (size == SIZE_WORD) ? RE_WORD : RE_BYTE;
    endfunction

    // Byte stores only carry the low byte; upper bits are cleared
    function automatic logic [DATA_W-1:0] store_data(input logic size,
                                                     input logic [DATA_W-1:0] wdata);
        return (size == SIZE_WORD) ? wdata : {24'h0, wdata[7:0]};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: passes a full word through, or takes the low byte of
// the memory word and extends it to 32 bits.
// Optional feature macro: LSU_SIGN_EXT_EN -- when defined, a byte load with
// is_signed=1 is sign-extended from bit 7; otherwise byte loads are always
// zero-extended and is_signed is ignored.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] raw_data,
    input  logic              size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] load_data
);

    logic ext_bit;

`ifdef LSU_SIGN_EXT_EN
    // Fill value for the upper 24 bits of a byte load
    assign ext_bit = is_signed & raw_data[7];
`else
    logic unused_is_signed;
    // Byte loads are always zero-extended in this build
    assign ext_bit          = 1'b0;
    assign unused_is_signed = is_signed;
`endif

    assign load_data[7:0] = raw_data[7:0];

    genvar gi;
    generate
        for (gi = 8; gi < DATA_W; gi++) begin : g_upper
            // Word loads keep the memory bit, byte loads take the fill value
            assign load_data[gi] = (size == SIZE_WORD) ? raw_data[gi] : ext_bit;
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request/response port and
// a synchronous data memory (read data registered by the memory).
// Sequence: IDLE -> STORE -> RESP, or IDLE -> LD_ISSUE -> LD_CAPT -> RESP.
// Optional feature macro: LSU_SIGN_EXT_EN (signed byte loads, see lsu_load_align).
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic              req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_write_enable,
    output logic [1:0]        mem_read_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_reg;
    logic              size_reg;
    logic              signed_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [1:0]        mem_we_reg;
    logic [1:0]        mem_re_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] load_aligned;

    // Width/extension of the returned load word, from the captured request
    lsu_load_align u_load_align (
        .raw_data  (mem_read_data),
        .size      (size_reg),
        .is_signed (signed_reg),
        .load_data (load_aligned)
    );

    // Control FSM with all memory-side and response outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            size_reg        <= SIZE_BYTE;
            signed_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            mem_address_reg <= '0;
            mem_we_reg      <= WE_NONE;
            mem_re_reg      <= RE_BYTE;
            mem_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        size_reg        <= req_size;
                        signed_reg      <= req_signed;
                        mem_address_reg <= req_addr;
                        if (req_store) begin
                            mem_we_reg    <= we_code(req_size);
                            mem_wdata_reg <= store_data(req_size, req_wdata);
                            state_reg     <= STORE;
                        end else begin
                            mem_re_reg <= re_code(req_size);
                            state_reg  <= LD_ISSUE;
                        end
                    end
                end
                STORE: begin
                    // Write strobe lasts exactly this one cycle
                    mem_we_reg    <= WE_NONE;
                    rsp_data_reg  <= '0;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                LD_ISSUE: begin
                    // Memory samples address/size at this edge
                    mem_re_reg <= RE_BYTE;
                    state_reg  <= LD_CAPT;
                end
                LD_CAPT: begin
                    rsp_data_reg  <= load_aligned;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    mem_we_reg    <= WE_NONE;
                    mem_re_reg    <= RE_BYTE;
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Ready comes straight from the state register, so it is 1 during reset
    assign req_ready        = (state_reg == IDLE);
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_data         = rsp_data_reg;
    assign mem_address      = mem_address_reg;
    assign mem_write_enable = mem_we_reg;
    assign mem_read_enable  = mem_re_reg;
    assign mem_write_data   = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// synchronous data memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic        req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [11:0] mem_address;
    logic [1:0]  mem_write_enable;
    logic [1:0]  mem_read_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;
    int we_cycles = 0;

    logic [31:0] mem_model [0:4095];
    bit          mem_written [0:4095];

`ifdef LSU_SIGN_EXT_EN
    localparam logic [31:0] EXP_SIGNED_BYTE = 32'hFFFFFF80;
`else
    localparam logic [31:0] EXP_SIGNED_BYTE = 32'h00000080;
`endif

    load_store_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_store        (req_store),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded contents for addresses never written by the DUT
    function automatic logic [31:0] default_word(input logic [11:0] a);
        case (a)
            12'd32:  return 32'hDEADBEEF;
            12'd40:  return 32'h00000080;
            12'd48:  return 32'h123456F0;
            12'd56:  return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    // Synchronous memory: registered read, write on the enable code
    always @(posedge clk) begin
        if (mem_write_enable == 2'b10) begin
            mem_model[mem_address]   <= mem_write_data;
            mem_written[mem_address] <= 1'b1;
        end else if (mem_write_enable == 2'b01) begin
            mem_model[mem_address]   <= {24'h0, mem_write_data[7:0]};
            mem_written[mem_address] <= 1'b1;
        end
        mem_read_data <= mem_written[mem_address] ? mem_model[mem_address]
                                                  : default_word(mem_address);
    end

    // Count clock cycles in which a write strobe was presented to memory
    always @(posedge clk) begin
        if (reset_n && mem_write_enable != 2'b00) we_cycles <= we_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic st, input logic sz, input logic sg,
                             input logic [11:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
    endtask

    // Full load transaction: three edges to rsp_valid, then handshake
    task automatic run_load(input string tag, input logic [11:0] a, input logic sz,
                            input logic sg, input logic [31:0] exp);
        check({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
        drive_req(1'b0, sz, sg, a, 32'h0);
        step();
        req_valid = 1'b0;
        check({tag, " re issue"}, {30'h0, mem_read_enable}, sz ? 32'h1 : 32'h0);
        check({tag, " addr"}, {20'h0, mem_address}, {20'h0, a});
        step();
        check({tag, " early rsp"}, {31'h0, rsp_valid}, 32'h0);
        step();
        check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, " rsp_data"}, rsp_data, exp);
        $display("load  addr=%0d size=%0d signed=%0d data=%h", a, sz, sg, rsp_data);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, " idle"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          we_base;
        logic [31:0] held;

        reset_n = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 1'b0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst rsp_data", rsp_data, 32'h0);
        check("rst we", {30'h0, mem_write_enable}, 32'h0);
        check("rst re", {30'h0, mem_read_enable}, 32'h0);
        check("rst addr", {20'h0, mem_address}, 32'h0);
        check("rst wdata", mem_write_data, 32'h0);

        // Byte store presented in the same cycle reset is released
        step();
        reset_n = 1'b1;
        we_base = we_cycles;
        drive_req(1'b1, 1'b0, 1'b0, 12'd16, 32'h123456AA);
        step();
        req_valid = 1'b0;
        check("bst we", {30'h0, mem_write_enable}, 32'h1);
        check("bst wdata", mem_write_data, 32'h000000AA);
        check("bst addr", {20'h0, mem_address}, 32'd16);
        check("bst busy", {31'h0, req_ready}, 32'h0);
        check("bst early rsp", {31'h0, rsp_valid}, 32'h0);
        step();
        check("bst rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("bst rsp_data", rsp_data, 32'h0);
        check("bst we off", {30'h0, mem_write_enable}, 32'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bst idle", {31'h0, req_ready}, 32'h1);
        check("bst we cycles", we_cycles - we_base, 32'd1);
        $display("store addr=16 size=0 data=%h", 32'h123456AA);

        run_load("wld", 12'd32, 1'b1, 1'b0, 32'hDEADBEEF);
        run_load("sbld", 12'd40, 1'b0, 1'b1, EXP_SIGNED_BYTE);
        run_load("ubld", 12'd48, 1'b0, 1'b0, 32'h000000F0);
        run_load("bst readback", 12'd16, 1'b1, 1'b0, 32'h000000AA);

        // Backpressure: response held while a competing request waits
        drive_req(1'b0, 1'b1, 1'b0, 12'd56, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        step();
        held = rsp_data;
        check("bp data", held, 32'hCAFEF00D);
        we_base = we_cycles;
        drive_req(1'b1, 1'b1, 1'b0, 12'd100, 32'h55555555);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp rsp_data", rsp_data, held);
            check("bp req_ready", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp release", {31'h0, rsp_valid}, 32'h0);
        check("bp no store", we_cycles - we_base, 32'd0);
        $display("load  addr=56 backpressured data=%h", held);

        // Word store, then read it back
        drive_req(1'b1, 1'b1, 1'b0, 12'd200, 32'h89ABCDEF);
        step();
        req_valid = 1'b0;
        check("wst we", {30'h0, mem_write_enable}, 32'h2);
        check("wst wdata", mem_write_data, 32'h89ABCDEF);
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("store addr=200 size=1 data=%h", 32'h89ABCDEF);
        run_load("wst readback", 12'd200, 1'b1, 1'b0, 32'h89ABCDEF);

        // Reset while in LD_CAPT
        drive_req(1'b0, 1'b1, 1'b0, 12'd32, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("mrst req_ready", {31'h0, req_ready}, 32'h1);
        check("mrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mrst rsp_data", rsp_data, 32'h0);
        check("mrst we", {30'h0, mem_write_enable}, 32'h0);
        check("mrst re", {30'h0, mem_read_enable}, 32'h0);
        check("mrst addr", {20'h0, mem_address}, 32'h0);
        check("mrst wdata", mem_write_data, 32'h0);
        step();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        we_base = we_cycles;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst no rsp", {31'h0, rsp_valid}, 32'h0);
        end
        check("mrst no write", we_cycles - we_base, 32'd0);
        rsp_ready = 1'b0;
        $display("reset during load: transaction abandoned");

        run_load("post rst", 12'd32, 1'b1, 1'b0, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
